// File: rtl/lspc_pkg.sv
// Shared constants for the LSPC raster timer: mode bit positions, FSM state
// codes and the PAL stop-window line bounds.
package lspc_pkg;

  localparam int unsigned CNT_W          = 32;
  localparam int unsigned PAL_FIRST_STOP = 16;
  localparam int unsigned PAL_LAST_STOP  = 248;

  localparam int unsigned MODE_IRQ_EN       = 4;
  localparam int unsigned MODE_RELOAD_WRLOW = 5;
  localparam int unsigned MODE_RELOAD_FRAME = 6;
  localparam int unsigned MODE_RELOAD_ZERO  = 7;
  localparam int unsigned MODE_PAL_STOP     = 8;

  localparam logic [0:0] STOPPED = 1'b0;
  localparam logic [0:0] RUN     = 1'b1;

  typedef struct packed {
    logic pal_stop;
    logic reload_zero;
    logic reload_frame;
    logic reload_wrlow;
    logic irq_en;
  } mode_t;

endpackage

// File: rtl/lspc_timer_irq_if.sv
// CPU/video-side signal bundle of the raster timer. The master side drives the
// strobes and raster position; the slave side is the timer itself.
interface lspc_timer_irq_if;
  import lspc_pkg::*;

  logic             CLK_EN;
  logic             WR_TIMER_HIGH;
  logic             WR_TIMER_LOW;
  logic             WR_MODE;
  logic [15:0]      M68K_DATA;
  logic             FRAME_START;
  logic [8:0]       VCOUNT;
  logic             PAL_MODE;
  logic             TIMER_IRQ;
  logic [CNT_W-1:0] TIMER_CNT;

  modport master (
    output CLK_EN, WR_TIMER_HIGH, WR_TIMER_LOW, WR_MODE, M68K_DATA,
    output FRAME_START, VCOUNT, PAL_MODE,
    input  TIMER_IRQ, TIMER_CNT
  );

  modport slave (
    input  CLK_EN, WR_TIMER_HIGH, WR_TIMER_LOW, WR_MODE, M68K_DATA,
    input  FRAME_START, VCOUNT, PAL_MODE,
    output TIMER_IRQ, TIMER_CNT
  );

endinterface

// File: rtl/lspc_timer_stop_window.sv
// PAL border stop window: registers the raster-line compare and gates pixel
// ticks off while a PAL board with PAL_STOP set is inside the top/bottom window.
module lspc_timer_stop_window
  import lspc_pkg::*;
#(
  parameter int unsigned FirstStop = PAL_FIRST_STOP,
  parameter int unsigned LastStop  = PAL_LAST_STOP
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [8:0] i_vcount,
  input  logic       i_pal_mode,
  input  logic       i_pal_stop,
  output logic       o_tick_gate
);

  localparam logic [8:0] FirstLine = 9'(FirstStop);
  localparam logic [8:0] LastLine  = 9'(LastStop);

  logic w_in_window;
  logic r_in_window;

  assign w_in_window = (i_vcount < FirstLine) || (i_vcount >= LastLine);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_in_window <= 1'b0;
    end else begin
      r_in_window <= w_in_window;
    end
  end

  assign o_tick_gate = ~(i_pal_mode & i_pal_stop & r_in_window);

endmodule

// File: rtl/lspc_timer_irq.sv
// LSPC programmable raster timer: 32-bit reloadable down-counter on the pixel
// tick, one-CLK TIMER_IRQ on expiry. Optional PAL stop window: TIMER_PAL_STOP_EN.
module lspc_timer_irq
  import lspc_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  lspc_timer_irq_if.slave   bus
);

  logic [CNT_W-1:0] r_reload;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  mode_t            r_mode;
  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic             r_irq;
  logic             w_irq_nxt;
  logic             w_tick_gate;
  logic             w_tick;

`ifdef TIMER_PAL_STOP_EN
  lspc_timer_stop_window #(
    .FirstStop (PAL_FIRST_STOP),
    .LastStop  (PAL_LAST_STOP)
  ) u_stop_window (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_vcount    (bus.VCOUNT),
    .i_pal_mode  (bus.PAL_MODE),
    .i_pal_stop  (r_mode.pal_stop),
    .o_tick_gate (w_tick_gate)
  );
`else
  logic w_unused_pal;
  assign w_unused_pal = ^{bus.VCOUNT, bus.PAL_MODE, r_mode.pal_stop};
  assign w_tick_gate  = 1'b1;
`endif

  assign w_tick = bus.CLK_EN & w_tick_gate;

  // Reload events win over ticks; a tick arriving alongside a reload is dropped.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    w_irq_nxt   = 1'b0;
    if (bus.WR_TIMER_LOW && r_mode.reload_wrlow) begin
      w_cnt_nxt   = {r_reload[CNT_W-1:16], bus.M68K_DATA};
      w_state_nxt = RUN;
    end else if (bus.FRAME_START && r_mode.reload_frame) begin
      w_cnt_nxt   = r_reload;
      w_state_nxt = RUN;
    end else if ((r_state == RUN) && w_tick) begin
      if (r_cnt == '0) begin
        w_irq_nxt = r_mode.irq_en;
        if (r_mode.reload_zero) begin
          w_cnt_nxt = r_reload;
        end else begin
          w_state_nxt = STOPPED;
        end
      end else begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt   <= '0;
      r_state <= STOPPED;
      r_irq   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      r_irq   <= w_irq_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_reload <= '0;
      r_mode   <= '0;
    end else begin
      if (bus.WR_TIMER_HIGH) begin
        r_reload[CNT_W-1:16] <= bus.M68K_DATA;
      end
      if (bus.WR_TIMER_LOW) begin
        r_reload[15:0] <= bus.M68K_DATA;
      end
      if (bus.WR_MODE) begin
        r_mode.irq_en       <= bus.M68K_DATA[MODE_IRQ_EN];
        r_mode.reload_wrlow <= bus.M68K_DATA[MODE_RELOAD_WRLOW];
        r_mode.reload_frame <= bus.M68K_DATA[MODE_RELOAD_FRAME];
        r_mode.reload_zero  <= bus.M68K_DATA[MODE_RELOAD_ZERO];
`ifdef TIMER_PAL_STOP_EN
        r_mode.pal_stop     <= bus.M68K_DATA[MODE_PAL_STOP];
`endif
      end
    end
  end

  assign bus.TIMER_IRQ = r_irq;
  assign bus.TIMER_CNT = r_cnt;

endmodule

// File: tb/tb_lspc_timer_irq.sv
// Directed self-checking bench for lspc_timer_irq; inputs change and outputs
// are sampled on the falling clock edge.
module tb_lspc_timer_irq;

  logic CLK;
  logic RESET;
  int   n_checks;
  int   n_fails;
  int   pulses[$];

  lspc_timer_irq_if bus ();

  lspc_timer_irq u_dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr_strobe(input int which, input logic [15:0] data);
    bus.M68K_DATA = data;
    case (which)
      0:       bus.WR_MODE       = 1'b1;
      1:       bus.WR_TIMER_HIGH = 1'b1;
      default: bus.WR_TIMER_LOW  = 1'b1;
    endcase
    @(negedge CLK);
    bus.WR_MODE       = 1'b0;
    bus.WR_TIMER_HIGH = 1'b0;
    bus.WR_TIMER_LOW  = 1'b0;
  endtask

  // Hold CLK_EN for n cycles and log the tick index of every IRQ pulse seen.
  task automatic run_ticks(input int n);
    pulses.delete();
    bus.CLK_EN = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge CLK);
      if (bus.TIMER_IRQ) pulses.push_back(i);
    end
    bus.CLK_EN = 1'b0;
  endtask

  initial begin
    n_checks          = 0;
    n_fails           = 0;
    RESET             = 1'b1;
    bus.CLK_EN        = 1'b0;
    bus.WR_TIMER_HIGH = 1'b0;
    bus.WR_TIMER_LOW  = 1'b0;
    bus.WR_MODE       = 1'b0;
    bus.M68K_DATA     = 16'h0;
    bus.FRAME_START   = 1'b0;
    bus.VCOUNT        = 9'd100;
    bus.PAL_MODE      = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("reset_cnt", bus.TIMER_CNT, 32'h0);
    check_eq("reset_irq", 32'(bus.TIMER_IRQ), 32'h0);
    RESET = 1'b0;

    // Idle timer never fires.
    run_ticks(1000);
    check_eq("idle_pulses", 32'(pulses.size()), 32'd0);
    check_eq("idle_cnt", bus.TIMER_CNT, 32'h0);

    // Auto-reload period N+1 with reload 3.
    wr_strobe(0, 16'h00B0);
    wr_strobe(1, 16'h0000);
    wr_strobe(2, 16'h0003);
    check_eq("wrlow_load", bus.TIMER_CNT, 32'h3);
    run_ticks(12);
    check_eq("auto_pulses", 32'(pulses.size()), 32'd3);
    if (pulses.size() == 3) begin
      check_eq("auto_p0", 32'(pulses[0]), 32'd4);
      check_eq("auto_p1", 32'(pulses[1]), 32'd8);
      check_eq("auto_p2", 32'(pulses[2]), 32'd12);
    end
    check_eq("auto_cnt", bus.TIMER_CNT, 32'h3);

    // One-shot: single pulse then stopped.
    wr_strobe(0, 16'h0030);
    wr_strobe(2, 16'h0002);
    run_ticks(3);
    check_eq("oneshot_pulses", 32'(pulses.size()), 32'd1);
    if (pulses.size() == 1) check_eq("oneshot_p0", 32'(pulses[0]), 32'd3);
    run_ticks(100);
    check_eq("stopped_pulses", 32'(pulses.size()), 32'd0);
    check_eq("stopped_cnt", bus.TIMER_CNT, 32'h0);

    // Frame reload with a coincident tick: tick discarded.
    wr_strobe(0, 16'h0050);
    wr_strobe(2, 16'h0010);
    check_eq("nowrlow_cnt", bus.TIMER_CNT, 32'h0);
    bus.FRAME_START = 1'b1;
    bus.CLK_EN      = 1'b1;
    @(negedge CLK);
    bus.FRAME_START = 1'b0;
    bus.CLK_EN      = 1'b0;
    check_eq("frame_load", bus.TIMER_CNT, 32'h10);
    run_ticks(17);
    check_eq("frame_pulses", 32'(pulses.size()), 32'd1);
    if (pulses.size() == 1) check_eq("frame_p0", 32'(pulses[0]), 32'd17);

    // Mode write coincident with expiry uses the old mode bits.
    wr_strobe(0, 16'h00B0);
    wr_strobe(2, 16'h0002);
    run_ticks(2);
    check_eq("pre_exp_cnt", bus.TIMER_CNT, 32'h0);
    bus.CLK_EN    = 1'b1;
    bus.WR_MODE   = 1'b1;
    bus.M68K_DATA = 16'h0000;
    @(negedge CLK);
    bus.CLK_EN  = 1'b0;
    bus.WR_MODE = 1'b0;
    check_eq("oldmode_irq", 32'(bus.TIMER_IRQ), 32'h1);
    check_eq("oldmode_reload", bus.TIMER_CNT, 32'h2);
    run_ticks(5);
    check_eq("newmode_pulses", 32'(pulses.size()), 32'd0);
    check_eq("newmode_cnt", bus.TIMER_CNT, 32'h0);

    // High-half write alongside a frame reload: reload uses the old high half.
    wr_strobe(0, 16'h0040);
    bus.FRAME_START   = 1'b1;
    bus.WR_TIMER_HIGH = 1'b1;
    bus.M68K_DATA     = 16'h0001;
    @(negedge CLK);
    bus.WR_TIMER_HIGH = 1'b0;
    check_eq("hi_old", bus.TIMER_CNT, 32'h0000_0002);
    @(negedge CLK);
    bus.FRAME_START = 1'b0;
    check_eq("hi_new", bus.TIMER_CNT, 32'h0001_0002);

    // Asynchronous reset mid-run clears everything.
    bus.CLK_EN = 1'b1;
    #2 RESET = 1'b1;
    #1;
    check_eq("async_rst_cnt", bus.TIMER_CNT, 32'h0);
    check_eq("async_rst_irq", 32'(bus.TIMER_IRQ), 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    run_ticks(10);
    check_eq("post_rst_pulses", 32'(pulses.size()), 32'd0);
    check_eq("post_rst_cnt", bus.TIMER_CNT, 32'h0);

`ifdef TIMER_PAL_STOP_EN
    // PAL border window freezes the counter; reloads still act.
    bus.PAL_MODE = 1'b1;
    bus.VCOUNT   = 9'd250;
    wr_strobe(0, 16'h0150);
    wr_strobe(2, 16'h0040);
    bus.FRAME_START = 1'b1;
    @(negedge CLK);
    bus.FRAME_START = 1'b0;
    check_eq("pal_load", bus.TIMER_CNT, 32'h40);
    run_ticks(50);
    check_eq("pal_frozen", bus.TIMER_CNT, 32'h40);
    bus.VCOUNT = 9'd20;
    @(negedge CLK);
    run_ticks(5);
    check_eq("pal_running", bus.TIMER_CNT, 32'h3B);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
